// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity type encodings and the
// parity/majority helpers used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Payload is zero-extended to 32 bits; extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [31:0] data, input logic par_typ);
        logic p;
        p = ^data;
        if (par_typ == PAR_ODD) begin
            calc_parity = ~p;
        end else begin
            calc_parity = p;
        end
    endfunction

    function automatic logic majority3(input logic [2:0] s);
        majority3 = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Bundle of the receiver's serial input, static configuration and result outputs.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      Par_Err;
    logic                      Stp_Err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit captures of the line and a 2-of-3 vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      run,
    input  logic                      clr,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      wrap,
    output logic                      sample_valid,
    output logic                      sampled_bit
);
    localparam logic [PRESCALE_WIDTH-1:0] ZERO = {PRESCALE_WIDTH{1'b0}};
    localparam logic [PRESCALE_WIDTH-1:0] ONE  = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] TWO  = PRESCALE_WIDTH'(2);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
    logic [PRESCALE_WIDTH-1:0] half_s;
    logic [2:0]                samp_r;

    assign half_s      = {1'b0, prescale[PRESCALE_WIDTH-1:1]};
    assign sampled_bit = majority3(samp_r);

    // Bit-boundary and vote-ready decode; both are quiet while no frame runs.
    always_comb begin
        wrap         = 1'b0;
        sample_valid = 1'b0;
        if (run) begin
            wrap         = (edge_cnt_r == prescale - ONE);
            sample_valid = (edge_cnt_r == half_s + TWO);
        end else begin
            wrap         = 1'b0;
            sample_valid = 1'b0;
        end
    end

    // Edge counter: the detecting edge is count 0, so the register holds the count of the current edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_r <= ZERO;
        end else if (clr || !run || (edge_cnt_r == prescale - ONE)) begin
            edge_cnt_r <= ZERO;
        end else begin
            edge_cnt_r <= edge_cnt_r + ONE;
        end
    end

    // Three captures around mid-bit; they hold until the next bit's first capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_r <= 3'b000;
        end else if (run) begin
            if (edge_cnt_r == half_s - ONE) samp_r[0] <= rx_in;
            if (edge_cnt_r == half_s)       samp_r[1] <= rx_in;
            if (edge_cnt_r == half_s + ONE) samp_r[2] <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start detection with glitch rejection, LSB-first deserialization,
// parity and stop checking, and registered one-cycle result strobes.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_core_if.slave bus
);
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ZERO = {BIT_CNT_W{1'b0}};
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    rx_state_e                 state_r, state_s;
    logic [PRESCALE_WIDTH-1:0] prescale_r, prescale_eff_s;
    logic                      par_en_r, par_typ_r, par_fail_r;
    logic [BIT_CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0]     shift_r, p_data_r;
    logic                      data_valid_r, par_err_r, stp_err_r;
    logic                      start_det_s, run_s, glitch_s;
    logic                      wrap_s, sample_valid_s, sampled_bit_s;

    assign start_det_s    = (state_r == ST_IDLE) && (bus.RX_IN == 1'b0);
    assign run_s          = (state_r != ST_IDLE) || start_det_s;
    assign glitch_s       = (state_r == ST_START) && sample_valid_s && sampled_bit_s;
    // Config is only latched at detection, so the detecting edge uses the live value.
    assign prescale_eff_s = (state_r == ST_IDLE) ? bus.Prescale : prescale_r;

    uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
        .CLK          (CLK),
        .RST          (RST),
        .run          (run_s),
        .clr          (glitch_s),
        .rx_in        (bus.RX_IN),
        .prescale     (prescale_eff_s),
        .wrap         (wrap_s),
        .sample_valid (sample_valid_s),
        .sampled_bit  (sampled_bit_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_r <= ST_IDLE;
        else      state_r <= state_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   if (start_det_s) state_s = ST_START; else state_s = ST_IDLE;
            ST_START:  if (glitch_s) state_s = ST_IDLE;
                       else if (wrap_s) state_s = ST_DATA;
                       else state_s = ST_START;
            ST_DATA:   if (wrap_s && (bit_cnt_r == LAST_BIT)) state_s = par_en_r ? ST_PARITY : ST_STOP;
                       else state_s = ST_DATA;
            ST_PARITY: if (wrap_s) state_s = ST_STOP; else state_s = ST_PARITY;
            ST_STOP:   if (wrap_s) state_s = ST_IDLE; else state_s = ST_STOP;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Datapath: config latch, shift register, parity tracking and result strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_r   <= {PRESCALE_WIDTH{1'b0}};
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            par_fail_r   <= 1'b0;
            bit_cnt_r    <= BIT_ZERO;
            shift_r      <= {DATA_WIDTH{1'b0}};
            p_data_r     <= {DATA_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_det_s) begin
                        prescale_r <= bus.Prescale;
                        par_en_r   <= bus.PAR_EN;
                        par_typ_r  <= bus.PAR_TYP;
                        par_fail_r <= 1'b0;
                        bit_cnt_r  <= BIT_ZERO;
                    end
                end
                ST_DATA: begin
                    if (sample_valid_s) shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
                    if (wrap_s) bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? BIT_ZERO : bit_cnt_r + BIT_ONE;
                end
                ST_PARITY: begin
                    if (sample_valid_s && (sampled_bit_s != calc_parity(32'(shift_r), par_typ_r)))
                        par_fail_r <= 1'b1;
                end
                ST_STOP: begin
                    // The vote of the stop bit is still held at the wrap edge.
                    if (wrap_s) begin
                        par_err_r <= par_fail_r;
                        stp_err_r <= ~sampled_bit_s;
                        if (!par_fail_r && sampled_bit_s) begin
                            p_data_r     <= shift_r;
                            data_valid_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_r;
    assign bus.Data_Valid = data_valid_r;
    assign bus.Par_Err    = par_err_r;
    assign bus.Stp_Err    = stp_err_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench: plans line waveforms and expected strobes per cycle from
// frame-level rules, plays them into the receiver and compares the outcomes.
module tb_uart_rx_core;
    localparam int DW   = 8;
    localparam int PW   = 6;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    uart_rx_core_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();
    uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    // Planned line/config per cycle, expected {Data_Valid,Par_Err,Stp_Err}, observations.
    bit         line_a [MAXC];
    int         cp_a   [MAXC];
    bit         cpe_a  [MAXC];
    bit         cpt_a  [MAXC];
    bit   [2:0] exp_f  [MAXC];
    logic [7:0] edat_a [MAXC];
    logic [2:0] obs_f  [MAXC];
    logic [7:0] obs_pd [MAXC];
    int         plen;
    int         cur_p  = 8;
    bit         cur_pe = 1'b0;
    bit         cur_pt = 1'b0;
    logic [7:0] plan_pdata = 8'h00;

    function automatic bit model_par(input logic [7:0] d, input bit pt);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return pt ? bit'((ones + 1) % 2) : bit'(ones % 2);
    endfunction

    task automatic plan_clear();
        plen = 0;
        for (int i = 0; i < MAXC; i++) begin
            line_a[i] = 1'b1; exp_f[i] = 3'b000; edat_a[i] = 8'h00;
        end
    endtask

    task automatic plan_raw(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            line_a[plen] = v; cp_a[plen] = cur_p; cpe_a[plen] = cur_pe; cpt_a[plen] = cur_pt;
            plen++;
        end
    endtask

    task automatic plan_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                              input bit par_bit, input bit stop_bit, input int glitch_bit);
        bit q[$];
        bit v, pfail;
        int last;
        cur_p = p; cur_pe = pe; cur_pt = pt;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back(par_bit);
        q.push_back(stop_bit);
        for (int b = 0; b < q.size(); b++) begin
            for (int c = 0; c < p; c++) begin
                v = q[b];
                if (glitch_bit >= 0 && b == glitch_bit + 1 && c == p / 2) v = ~v;
                line_a[plen] = v; cp_a[plen] = p; cpe_a[plen] = pe; cpt_a[plen] = pt;
                plen++;
            end
        end
        last  = plen - 1;
        pfail = pe && (par_bit != model_par(d, pt));
        exp_f[last]  = {!pfail && stop_bit, pfail, !stop_bit};
        edat_a[last] = d;
        if (!pfail && stop_bit) plan_pdata = d;
    endtask

    task automatic play(input int upto);
        for (int k = 0; k < upto; k++) begin
            bus.RX_IN = line_a[k]; bus.Prescale = PW'(cp_a[k]);
            bus.PAR_EN = cpe_a[k]; bus.PAR_TYP = cpt_a[k];
            @(posedge clk);
            @(negedge clk);
            obs_f[k]  = {bus.Data_Valid, bus.Par_Err, bus.Stp_Err};
            obs_pd[k] = bus.P_DATA;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Prescale = PW'(8);
        repeat (3) @(negedge clk);
        total++;
        if ({bus.Data_Valid, bus.Par_Err, bus.Stp_Err, bus.P_DATA} !== 11'h000) begin
            bad++; $display("FAIL reset_outputs got=%h exp=000", {bus.Data_Valid, bus.Par_Err, bus.Stp_Err, bus.P_DATA});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.Data_Valid, bus.Par_Err, bus.Stp_Err, bus.P_DATA} !== 11'h000) begin
            bad++; $display("FAIL reset_idle got=%h exp=000", {bus.Data_Valid, bus.Par_Err, bus.Stp_Err, bus.P_DATA});
        end
    endtask

    task automatic test_parity_good();
        int s, first_dv;
        plan_clear(); plan_raw(1'b1, 2); s = plen;
        plan_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1); plan_raw(1'b1, 3);
        play(plen);
        first_dv = -1;
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL parity_good_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
            if (obs_f[k][2] === 1'b1 && first_dv < 0) first_dv = k;
        end
        total++;
        if (first_dv != s + 87) begin bad++; $display("FAIL parity_good_latency got=%0d exp=%0d", first_dv, s + 87); end
        total++;
        if (obs_pd[plen-1] !== 8'hA5) begin bad++; $display("FAIL parity_good_data got=%h exp=a5", obs_pd[plen-1]); end
    endtask

    task automatic test_parity_err();
        plan_clear(); plan_raw(1'b1, 2);
        plan_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1); plan_raw(1'b1, 3);
        play(plen);
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL parity_err_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
        end
        total++;
        if (obs_pd[plen-1] !== 8'hA5) begin bad++; $display("FAIL parity_err_hold got=%h exp=a5", obs_pd[plen-1]); end
    endtask

    task automatic test_stop_err();
        plan_clear(); plan_raw(1'b1, 2);
        plan_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1); plan_raw(1'b1, 4);
        plan_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1); plan_raw(1'b1, 2);
        play(plen);
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL stop_err_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
        end
        total++;
        if (obs_pd[plen-1] !== 8'h81) begin bad++; $display("FAIL stop_err_next_data got=%h exp=81", obs_pd[plen-1]); end
    endtask

    task automatic test_glitch_start();
        plan_clear(); cur_p = 8; cur_pe = 1'b0; cur_pt = 1'b0;
        plan_raw(1'b1, 2); plan_raw(1'b0, 2); plan_raw(1'b1, 10);
        plan_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1); plan_raw(1'b1, 2);
        play(plen);
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL glitch_start_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
        end
        total++;
        if (obs_pd[plen-1] !== 8'h55) begin bad++; $display("FAIL glitch_start_data got=%h exp=55", obs_pd[plen-1]); end
    endtask

    task automatic test_data_glitch();
        plan_clear(); plan_raw(1'b1, 2);
        plan_frame(8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b1, 3); plan_raw(1'b1, 2);
        play(plen);
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL data_glitch_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
        end
        total++;
        if (obs_pd[plen-1] !== 8'h00) begin bad++; $display("FAIL data_glitch_data got=%h exp=00", obs_pd[plen-1]); end
    endtask

    task automatic test_back_to_back();
        int dv[$];
        plan_clear(); plan_raw(1'b1, 2);
        plan_frame(8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        plan_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1); plan_raw(1'b1, 2);
        play(plen);
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL b2b_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
            if (obs_f[k][2] === 1'b1) dv.push_back(k);
        end
        total++;
        if (dv.size() != 2) begin
            bad++; $display("FAIL b2b_pulse_count got=%0d exp=2", dv.size());
        end else begin
            total += 2;
            if (dv[1] - dv[0] != 320) begin bad++; $display("FAIL b2b_spacing got=%0d exp=320", dv[1] - dv[0]); end
            if ({obs_pd[dv[0]], obs_pd[dv[1]]} !== 16'h01FF) begin
                bad++; $display("FAIL b2b_data got=%h,%h exp=01,ff", obs_pd[dv[0]], obs_pd[dv[1]]);
            end
        end
    endtask

    task automatic test_reset_mid();
        plan_clear(); plan_raw(1'b1, 2);
        plan_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        play(40);
        total++;
        if (obs_pd[39] !== 8'hFF) begin bad++; $display("FAIL reset_mid_before got=%h exp=ff", obs_pd[39]); end
        rst = 1'b0; bus.RX_IN = 1'b1;
        #1;
        total++;
        if ({bus.Data_Valid, bus.Par_Err, bus.Stp_Err, bus.P_DATA} !== 11'h000) begin
            bad++; $display("FAIL reset_mid_outputs got=%h exp=000", {bus.Data_Valid, bus.Par_Err, bus.Stp_Err, bus.P_DATA});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; plan_pdata = 8'h00;
        plan_clear(); plan_raw(1'b1, 2);
        plan_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1); plan_raw(1'b1, 2);
        play(plen);
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL reset_mid_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
        end
        total++;
        if (obs_pd[plen-1] !== 8'h96) begin bad++; $display("FAIL reset_mid_data got=%h exp=96", obs_pd[plen-1]); end
    endtask

    task automatic test_random();
        int p, sel;
        bit pe, pt, par, stp;
        logic [7:0] d;
        plan_clear();
        for (int f = 0; f < 12; f++) begin
            sel = int'($urandom_range(0, 2));
            case (sel)
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pe  = bit'($urandom_range(0, 1));
            pt  = bit'($urandom_range(0, 1));
            d   = 8'($urandom);
            par = model_par(d, pt) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            plan_raw(1'b1, int'($urandom_range(0, 4)));
            plan_frame(d, p, pe, pt, par, stp, -1);
        end
        plan_raw(1'b1, 2);
        play(plen);
        for (int k = 0; k < plen; k++) begin
            total++;
            if (obs_f[k] !== exp_f[k]) begin bad++; $display("FAIL random_strobes cyc=%0d got=%b exp=%b", k, obs_f[k], exp_f[k]); end
            if (exp_f[k][2]) begin
                total++;
                if (obs_pd[k] !== edat_a[k]) begin bad++; $display("FAIL random_data cyc=%0d got=%h exp=%h", k, obs_pd[k], edat_a[k]); end
            end
        end
        total++;
        if (obs_pd[plen-1] !== plan_pdata) begin bad++; $display("FAIL random_final got=%h exp=%h", obs_pd[plen-1], plan_pdata); end
    endtask

    initial begin
        test_reset();
        test_parity_good();
        test_parity_err();
        test_stop_err();
        test_glitch_start();
        test_data_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
